// File: rtl/fixed_point_pkg.sv
// Shared definitions for the sign-magnitude Q7.8 fixed-point arithmetic blocks.
package fixed_point_pkg;
    localparam int FP_W = 16;
    localparam int FP_FRAC = 8;
    localparam logic [FP_W-2:0] FP_MAG_MAX = 15'h7FFF;

    typedef logic [FP_W-1:0] fp_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;
endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division step: shift in the next numerator bit and conditionally subtract.
module fixed_point_div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem,
    input  logic [W-2:0] den,
    input  logic         bit_in,
    output logic [W-1:0] rem_next,
    output logic         qbit
);
    logic [W:0] t;

    // Full-width trial value keeps the compare exact even if rem's MSB were set.
    assign t        = {rem, bit_in};
    assign qbit     = (t >= {2'b00, den});
    assign rem_next = qbit ? W'(t - {2'b00, den}) : t[W-1:0];
endmodule

// File: rtl/fixed_point_divider.sv
// Iterative sign-magnitude Q7.8 divider with valid/ready handshakes, one quotient bit per cycle.
//   state    | meaning
//   DIV_IDLE | waiting for operands, in_ready high
//   DIV_BUSY | shifting out ITER quotient bits, MSB first
//   DIV_DONE | result held until the consumer takes it
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int DATA_W = FP_W,
    parameter int FRAC_W = FP_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic              div_by_zero,
    output logic              overflow
);
    localparam int ITER = DATA_W - 1 + FRAC_W;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [DATA_W-2:0] MAG_MAX = '1;

    div_state_t        state;
    logic              sign;
    logic [ITER-1:0]   num;
    logic [ITER-1:0]   q;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-2:0] den;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] rem_next;
    logic              qbit;
    logic [ITER-1:0]   q_next;
    logic              sign_in;

    fixed_point_div_step #(.W(DATA_W)) u_step (
        .rem      (rem),
        .den      (den),
        .bit_in   (num[ITER-1]),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    assign q_next   = {q[ITER-2:0], qbit};
    assign sign_in  = dividend[DATA_W-1] ^ divisor[DATA_W-1];
    assign in_ready = (state == DIV_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DIV_IDLE;
            out_valid   <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            sign        <= 1'b0;
            num         <= '0;
            q           <= '0;
            rem         <= '0;
            den         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (in_valid) begin
                        sign <= sign_in;
                        num  <= {dividend[DATA_W-2:0], {FRAC_W{1'b0}}};
                        den  <= divisor[DATA_W-2:0];
                        rem  <= '0;
                        q    <= '0;
                        cnt  <= '0;
                        if (divisor[DATA_W-2:0] == '0) begin
                            state       <= DIV_DONE;
                            out_valid   <= 1'b1;
                            quotient    <= {sign_in, MAG_MAX};
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else begin
                            state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem <= rem_next;
                    num <= {num[ITER-2:0], 1'b0};
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state       <= DIV_DONE;
                        out_valid   <= 1'b1;
                        div_by_zero <= 1'b0;
                        // Any set bit above the 15-bit magnitude means the result cannot be represented.
                        if (q_next[ITER-1:DATA_W-1] != '0) begin
                            quotient <= {sign, MAG_MAX};
                            overflow <= 1'b1;
                        end else begin
                            quotient <= {sign, q_next[DATA_W-2:0]};
                            overflow <= 1'b0;
                        end
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        state       <= DIV_IDLE;
                        out_valid   <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed testbench for fixed_point_divider with hand-computed Q7.8 results.
module tb_fixed_point_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic        div_by_zero;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    fixed_point_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Presents operands for one edge; reports whether in_ready was high before that edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, output logic rdy);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        #1 rdy = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; notes any in_ready seen meanwhile.
    task automatic wait_result(output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 60) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (quotient !== 16'h0000) begin miscompares++; $display("FAIL reset_quotient got %h want 0000", quotient); end
        vectors++; if ({div_by_zero, overflow} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {div_by_zero, overflow}); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic rdy, rdy_seen;
        int lat;
        start_op(16'h0600, 16'h0200, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL basic_accept_ready got %b want 1", rdy); end
        vectors++; if (lat != 23) begin miscompares++; $display("FAIL basic_latency got %0d want 23", lat); end
        vectors++; if (rdy_seen !== 1'b0) begin miscompares++; $display("FAIL basic_busy_in_ready got %b want 0", rdy_seen); end
        vectors++; if (quotient !== 16'h0300) begin miscompares++; $display("FAIL basic_quotient got %h want 0300", quotient); end
        vectors++; if ({div_by_zero, overflow} !== 2'b00) begin miscompares++; $display("FAIL basic_flags got %b want 00", {div_by_zero, overflow}); end
        release_result();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_signed_trunc();
        logic rdy, rdy_seen;
        int lat;
        start_op(16'h8180, 16'h0080, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (quotient !== 16'h8300) begin miscompares++; $display("FAIL neg_quotient got %h want 8300", quotient); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL neg_overflow got %b want 0", overflow); end
        release_result();
        start_op(16'h0100, 16'h0300, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (quotient !== 16'h0055) begin miscompares++; $display("FAIL trunc_quotient got %h want 0055", quotient); end
        vectors++; if (lat != 23) begin miscompares++; $display("FAIL trunc_latency got %0d want 23", lat); end
        release_result();
    endtask

    task automatic test_overflow();
        logic rdy, rdy_seen;
        int lat;
        start_op(16'h6400, 16'h0040, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (quotient !== 16'h7FFF) begin miscompares++; $display("FAIL ovf_pos_quotient got %h want 7fff", quotient); end
        vectors++; if ({div_by_zero, overflow} !== 2'b01) begin miscompares++; $display("FAIL ovf_pos_flags got %b want 01", {div_by_zero, overflow}); end
        release_result();
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_drop got %b want 0", overflow); end
        start_op(16'hE400, 16'h0040, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (quotient !== 16'hFFFF) begin miscompares++; $display("FAIL ovf_neg_quotient got %h want ffff", quotient); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_neg_flag got %b want 1", overflow); end
        release_result();
    endtask

    task automatic test_div_by_zero();
        logic rdy, rdy_seen;
        int lat;
        start_op(16'h0100, 16'h8000, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (lat != 0) begin miscompares++; $display("FAIL dbz_latency got %0d want 0 edges past accept", lat); end
        vectors++; if (quotient !== 16'hFFFF) begin miscompares++; $display("FAIL dbz_quotient got %h want ffff", quotient); end
        vectors++; if ({div_by_zero, overflow} !== 2'b10) begin miscompares++; $display("FAIL dbz_flags got %b want 10", {div_by_zero, overflow}); end
        release_result();
        vectors++; if ({out_valid, div_by_zero} !== 2'b00) begin miscompares++; $display("FAIL dbz_drop got %b want 00", {out_valid, div_by_zero}); end
    endtask

    task automatic test_back_to_back();
        logic rdy, rdy_seen;
        int lat;
        start_op(16'h0600, 16'h0200, rdy);
        wait_result(lat, rdy_seen);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dividend = 16'h0100;
            divisor  = 16'h8000;
            in_valid = 1'b1;
            #1;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
            @(posedge clk);
            #1;
            vectors++; if ({out_valid, quotient, div_by_zero, overflow} !== {1'b1, 16'h0300, 2'b00}) begin
                miscompares++; $display("FAIL bp_hold cycle %0d got v=%b q=%h f=%b want v=1 q=0300 f=00", i, out_valid, quotient, {div_by_zero, overflow});
            end
        end
        in_valid = 1'b0;
        release_result();
        vectors++; if ({out_valid, in_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_release got valid/ready %b want 01", {out_valid, in_ready}); end
        start_op(16'h0100, 16'h0300, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_first_ready got %b want 1", rdy); end
        vectors++; if (quotient !== 16'h0055) begin miscompares++; $display("FAIL b2b_first_quotient got %h want 0055", quotient); end
        release_result();
        start_op(16'h0400, 16'h0200, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_ready got %b want 1", rdy); end
        vectors++; if (quotient !== 16'h0200) begin miscompares++; $display("FAIL b2b_second_quotient got %h want 0200", quotient); end
        release_result();
    endtask

    task automatic test_reset_mid_busy();
        logic rdy, rdy_seen;
        int lat;
        logic valid_seen;
        start_op(16'h6400, 16'h0040, rdy);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if ({out_valid, quotient, div_by_zero, overflow, in_ready} !== 20'h0) begin
            miscompares++; $display("FAIL mid_reset_outputs got v=%b q=%h f=%b r=%b want all 0", out_valid, quotient, {div_by_zero, overflow}, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready got %b want 1", in_ready); end
        valid_seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1 if (out_valid) valid_seen = 1'b1;
        end
        vectors++; if (valid_seen !== 1'b0) begin miscompares++; $display("FAIL aborted_result got out_valid %b want 0", valid_seen); end
        start_op(16'h0400, 16'h0200, rdy);
        wait_result(lat, rdy_seen);
        vectors++; if (lat != 23) begin miscompares++; $display("FAIL post_abort_latency got %0d want 23", lat); end
        vectors++; if (quotient !== 16'h0200) begin miscompares++; $display("FAIL post_abort_quotient got %h want 0200", quotient); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_trunc();
        test_overflow();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
